// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word memory between fetch (IF) and load/store (D) requesters
//   clk, rst_n                                      clock, asynchronous active-low reset
//   if_req/if_addr -> if_ack/if_rdata               fetch port, ack is a one-cycle pulse
//   d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata      load/store port, ack is a one-cycle pulse
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata     shared memory interface
//   arb_busy                                        high while an access is in flight
//   MEM_ARB_RR_EN                                   defined: alternate owners on collision; else D always wins
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_busy
);
  localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic owner_d, store, grant_d, any_req;
  assign any_req  = if_req | d_req;
  assign arb_busy = state != IDLE;
`ifdef MEM_ARB_RR_EN
  logic last_owner;
  // on collision the requester that was not served last wins
  assign grant_d = d_req && !(if_req && last_owner);
`else
  assign grant_d = d_req;
`endif
  always_comb begin
    state_n = state;
    if (state == IDLE && any_req) state_n = ACCESS;
    else if (state == ACCESS && cnt == '0) state_n = RESP;
    else if (state == RESP) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      owner_d   <= 1'b0;
      store     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner <= 1'b0;
`endif
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          owner_d   <= grant_d;
          store     <= grant_d && d_we;
          mem_en    <= 1'b1;
          // the write strobe is registered, so it is raised one edge ahead of the final access cycle
          mem_we    <= grant_d && d_we && (MEM_LATENCY == 1);
          mem_addr  <= grant_d ? d_addr : if_addr;
          mem_wdata <= grant_d ? d_wdata : '0;
          cnt       <= CNT_INIT;
`ifdef MEM_ARB_RR_EN
          last_owner <= grant_d;
`endif
        end
        ACCESS: if (cnt == '0) begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          d_ack  <= owner_d;
          if_ack <= !owner_d;
          if (!store && owner_d) d_rdata <= mem_rdata;
          if (!owner_d) if_rdata <= mem_rdata;
        end else begin
          cnt    <= cnt - 1'b1;
          mem_we <= store && cnt == CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with MEM_LATENCY=2
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n, if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, arb_busy, preload;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:1023];
  int cyc = 0, passed = 0, total = 0, t;
  logic [31:0] last_d;
  typedef struct {logic is_d; logic [31:0] data; int cyc;} exp_t;
  exp_t sb[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .arb_busy(arb_busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk)
    if (preload) begin
      mem[2]   <= 32'h8001060A;
      mem[256] <= 32'h12345678;
    end else if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic push(input logic is_d, input logic [31:0] data, input int at);
    exp_t e;
    e.is_d = is_d; e.data = data; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input logic is_d);
    int n = 0;
    while (!(is_d ? d_ack : if_ack) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk(is_d ? "d_ack_timeout" : "if_ack_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk)
    if (if_ack || d_ack) begin
      exp_t e;
      if (sb.size() == 0) chk("unexpected_ack", {30'd0, d_ack, if_ack}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("ack_owner", {30'd0, d_ack, if_ack}, e.is_d ? 32'd2 : 32'd1);
        chk("ack_rdata", e.is_d ? d_rdata : if_rdata, e.data);
        chk("ack_cycle", cyc, e.cyc);
      end
    end

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      preload = 1'b0;
      if_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
      chk("rst_ctrl", {27'd0, if_ack, d_ack, mem_en, mem_we, arb_busy}, 32'd0);
      chk("rst_data", mem_addr | mem_wdata | if_rdata | d_rdata, 32'd0);
    end
    if_req = 0; d_req = 0; d_we = 0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_grant", {30'd0, mem_en, arb_busy}, 32'd0);

    if_req = 1; if_addr = 32'h8; t = cyc;
    push(0, 32'h8001060A, t + 3);
    @(negedge clk) chk("fetch_en_t1", {31'd0, mem_en}, 32'd1);
    chk("fetch_addr", mem_addr, 32'h8);
    @(negedge clk) chk("fetch_en_t2", {30'd0, mem_en, mem_we}, 32'd2);
    wait_ack(0);
    chk("fetch_en_off", {31'd0, mem_en}, 32'd0);
    if_req = 0;
    repeat (2) @(negedge clk);

    if_req = 1; if_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h400; t = cyc;
    push(1, 32'h12345678, t + 3);
    push(0, 32'h8001060A, t + 7);
    @(negedge clk) chk("collide_addr", mem_addr, 32'h400);
    wait_ack(1);
    d_req = 0;
    wait_ack(0);
    if_req = 0;
    last_d = 32'h12345678;
    repeat (2) @(negedge clk);

    d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'h60A; t = cyc;
    push(1, last_d, t + 3);
    @(negedge clk) chk("store_we_t1", {31'd0, mem_we}, 32'd0);
    @(negedge clk) chk("store_we_t2", {31'd0, mem_we}, 32'd1);
    chk("store_wdata", mem_wdata, 32'h60A);
    wait_ack(1);
    chk("store_we_t3", {31'd0, mem_we}, 32'd0);
    d_req = 0; d_we = 0;
    @(negedge clk);
    d_req = 1; d_addr = 32'h400; t = cyc;
    push(1, 32'h60A, t + 3);
    wait_ack(1);
    d_req = 0;
    repeat (2) @(negedge clk);

    d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'hDEAD; t = cyc;
    @(negedge clk) rst_n = 1'b0;
    d_req = 0; d_we = 0;
    #1 chk("rst_mid_en", {30'd0, mem_en, arb_busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_mid_mem", mem[256], 32'h60A);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    if_req = 1; if_addr = 32'h8; d_req = 1; d_addr = 32'h400; t = cyc;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      push(k % 2 == 0, (k % 2 == 0) ? 32'h60A : 32'h8001060A, t + 3 + 4 * k);
`else
      push(1, 32'h60A, t + 3 + 4 * k);
`endif
    end
    while (cyc < t + 15) @(negedge clk);
    if_req = 0; d_req = 0;
    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    chk("end_idle", {31'd0, arb_busy}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
